// File: rtl/cpu_boot_loader.sv
// Host-side boot loader: assembles a byte stream into 32-bit words, writes them
// into instruction memory with the core held in reset, then runs the core and reports the outcome.
module cpu_boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              CP,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_done,
    input  logic              cpu_err,
    output logic              busy,
    output logic [1:0]        status,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] len;
    logic [23:0]       asm_buf;
    logic              xfer;
    logic              last_wr;
    logic              run_tmo;
    logic [31:0]       cnt_inc;

    assign xfer    = rx_valid && rx_ready;
    assign cnt_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign run_tmo = (cnt_inc >= 32'(TIMEOUT));
    // len==0 wraps to all-ones, so a 256-word load ends on address 255
    assign last_wr = imem_we && (imem_addr == len - 1'b1);

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: if (xfer) state_nxt = LOAD;
            LOAD:       if (last_wr) state_nxt = RUN;
            RUN:        if (cpu_err || cpu_done || run_tmo) state_nxt = HALT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = (state != RUN);
        cpu_reset = (state != RUN);
        busy      = (state == LOAD) || (state == RUN);
    end

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            byte_idx    <= '0;
            word_idx    <= '0;
            len         <= '0;
            asm_buf     <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            status      <= 2'b00;
            cycle_count <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (xfer) begin
                        len         <= ADDR_W'(rx_data);
                        byte_idx    <= '0;
                        word_idx    <= '0;
                        status      <= 2'b00;
                        cycle_count <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= {rx_data, asm_buf};
                            word_idx   <= word_idx + 1'b1;
                        end else begin
                            asm_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                        end
                    end
                end
                RUN: begin
                    cycle_count <= cnt_inc;
                    if (cpu_err)       status <= 2'b10;
                    else if (cpu_done) status <= 2'b01;
                    else if (run_tmo)  status <= 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Scoreboard bench for cpu_boot_loader: stimulus pushes expected writes/results,
// a forked monitor pops and compares whenever the DUT presents them.
module tb_cpu_boot_loader;

    logic        CP;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        cpu_done;
    logic        cpu_err;
    logic        busy;
    logic [1:0]  status;
    logic [31:0] cycle_count;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cnt;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    int   checks   = 0;
    int   failures = 0;

    cpu_boot_loader #(.ADDR_W(8), .TIMEOUT(4096)) dut (
        .CP(CP), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_done(cpu_done),
        .cpu_err(cpu_err), .busy(busy), .status(status), .cycle_count(cycle_count)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        bit  prev_cr  = 1'b1;
        bit  chk_next = 1'b0;
        wr_t w;
        res_t r;
        forever begin
            @(negedge CP);
            if (chk_next) begin
                chk("post_last_cpu_reset", 64'(cpu_reset), 64'd0);
                chk("post_last_busy", 64'(busy), 64'd1);
                chk_next = 1'b0;
            end
            if (imem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(imem_addr), 64'hFFFF);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 64'(imem_addr), 64'(w.addr));
                    chk("wr_data", 64'(imem_wdata), 64'(w.data));
                    chk_next = w.last;
                end
            end
            if (prev_cr == 1'b0 && cpu_reset === 1'b1) begin
                if (rq.size() == 0) begin
                    chk("unexpected_result", 64'(status), 64'hFFFF);
                end else begin
                    r = rq.pop_front();
                    chk("res_status", 64'(status), 64'(r.st));
                    chk("res_count", 64'(cycle_count), 64'(r.cnt));
                    chk("res_busy", 64'(busy), 64'd0);
                end
            end
            prev_cr = (cpu_reset === 1'b1);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge CP);
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 100) begin
            @(negedge CP);
            n++;
        end
        if (n >= 100) chk("rx_ready_wait", 64'(n), 64'd0);
        @(negedge CP);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
    endtask

    task automatic wait_run();
        int n = 0;
        while (cpu_reset !== 1'b0 && n < 3000) begin
            @(negedge CP);
            n++;
        end
        if (n >= 3000) chk("wait_run_timeout", 64'(n), 64'd0);
    endtask

    task automatic wait_exit(input int lim);
        int n = 0;
        while (cpu_reset !== 1'b1 && n < lim) begin
            @(negedge CP);
            n++;
        end
        if (n >= lim) chk("wait_exit_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_done = 1'b0;
        cpu_err  = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge CP);
        chk("rst_ctl", 64'({rx_ready, imem_we, cpu_reset, busy, status, imem_addr}),
            64'({1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00}));
        chk("rst_data", 64'({imem_wdata, cycle_count}), 64'd0);
        reset = 1'b1;
        @(negedge CP);

        // Two-word load, done on the 10th RUN cycle
        send_byte(8'h02, 1'b0);
        chk("load_busy", 64'({busy, cpu_reset}), 64'b11);
        wq.push_back('{8'd0, 32'h1234_5678, 1'b0});
        wq.push_back('{8'd1, 32'hDEAD_BEEF, 1'b1});
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_run();
        rq.push_back('{2'b01, 32'd10});
        repeat (9) @(negedge CP);
        cpu_done = 1'b1;
        wait_exit(50);
        cpu_done = 1'b0;
        chk("halt_rx_ready", 64'(rx_ready), 64'd1);

        // New length in HALT clears status; err+done together reports err
        send_byte(8'h02, 1'b0);
        chk("halt_clear", 64'({status, cycle_count}), 64'd0);
        wq.push_back('{8'd0, 32'h0403_0201, 1'b0});
        wq.push_back('{8'd1, 32'h0807_0605, 1'b1});
        send_word(32'h0403_0201, 1'b0);
        send_word(32'h0807_0605, 1'b0);
        wait_run();
        chk("run_rx_ready", 64'(rx_ready), 64'd0);
        rq.push_back('{2'b10, 32'd4});
        repeat (3) @(negedge CP);
        cpu_done = 1'b1;
        cpu_err  = 1'b1;
        wait_exit(50);
        cpu_done = 1'b0;
        cpu_err  = 1'b0;

        // Timeout: no flags ever rise
        send_byte(8'h01, 1'b0);
        wq.push_back('{8'd0, 32'hA5A5_A5A5, 1'b1});
        send_word(32'hA5A5_A5A5, 1'b0);
        wait_run();
        rq.push_back('{2'b11, 32'd4096});
        wait_exit(5000);
        chk("tmo_cpu_reset", 64'(cpu_reset), 64'd1);

        // Length 0 = 256 words with random rx_valid gaps
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(255 - i), 8'h5A, 8'(i) ^ 8'h3C};
            wq.push_back('{8'(i), w, (i == 255)});
            send_word(w, 1'b1);
        end
        wait_run();
        rq.push_back('{2'b01, 32'd1});
        cpu_done = 1'b1;
        wait_exit(50);
        cpu_done = 1'b0;

        // Reset after 5 of 8 data bytes: word 0 already written, nothing after
        send_byte(8'h02, 1'b0);
        wq.push_back('{8'd0, 32'hCAFE_F00D, 1'b0});
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h11, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ctl", 64'({rx_ready, imem_we, cpu_reset, busy, status, imem_addr}),
            64'({1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00}));
        chk("midrst_data", 64'({imem_wdata, cycle_count}), 64'd0);
        repeat (3) @(negedge CP);
        reset = 1'b1;
        @(negedge CP);
        send_byte(8'h01, 1'b0);
        wq.push_back('{8'd0, 32'h0BAD_F00D, 1'b1});
        send_word(32'h0BAD_F00D, 1'b0);
        wait_run();
        rq.push_back('{2'b01, 32'd2});
        @(negedge CP);
        cpu_done = 1'b1;
        wait_exit(50);
        cpu_done = 1'b0;

        repeat (4) @(negedge CP);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
- Host-side counterpart of CPU_Top: the block that feeds the core and collects its result.
- Receives a program as a byte stream and assembles it into 32-bit words.
- Writes the words into instruction memory while holding the core in reset, then releases the core and reports the outcome.
- Outcomes: done, err, or timeout, plus the cycle count.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; matches the 8-bit PC.
- TIMEOUT, 4096, maximum RUN cycles before the run is aborted.

Ports:
- CP  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming program byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word being written.
- cpu_reset  output  1  active-high reset to CPU_Top.
- cpu_done  input  1  CPU done flag.
- cpu_err  input  1  CPU err flag.
- busy  output  1  loading or running.
- status  output  2  result: 00 none, 01 pass, 10 cpu error, 11 timeout.
- cycle_count  output  32  number of RUN cycles in the last or current run.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, busy=0, status=00, cycle_count=0.
  - Internal byte index and word count are cleared.
  - Asserting reset mid-load or mid-run aborts immediately with the same values; no partial memory write may be issued after reset asserts.
- Handshake:
  - A byte transfers on a rising edge where rx_valid=1 and rx_ready=1.
  - rx_ready=1 in IDLE, LOAD and HALT; 0 in RUN.
  - rx_data must be ignored when no transfer occurs.
- IDLE:
  - The first transferred byte is the length N in words; N=0 means 256.
  - On transfer: go to LOAD, busy=1, status=00, cycle_count=0, word index=0.
- LOAD:
  - Bytes are assembled little-endian: byte k of a word goes to bits [8k+7:8k].
  - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr=word index and imem_wdata=the assembled word; the word index then increments.
  - Byte transfers continue during the write cycle.
  - After the write of word N-1, the next state is RUN.
  - cpu_reset stays 1 throughout IDLE and LOAD.
  - Word index wraps only at 256, i.e. exactly when N=0 and the last word is written.
- RUN:
  - cpu_reset=0 from the first RUN cycle.
  - cycle_count increments by 1 every RUN cycle, saturating at 2^32-1.
  - cpu_done and cpu_err are sampled each RUN cycle. Exit conditions, in priority order:
    1. cpu_err=1 → status=10.
    2. else cpu_done=1 → status=01.
    3. else cycle_count reaching TIMEOUT → status=11.
  - If cpu_err and cpu_done are high together, status=10.
  - On exit the next state is HALT and cpu_reset=1 from the next cycle.
  - cycle_count freezes at its value in the exit cycle.
- HALT:
  - busy=0; status and cycle_count hold.
  - A transferred byte is a new length: behave as IDLE and clear status and cycle_count.
- General:
  - imem_we is never asserted outside LOAD.
  - cpu_done and cpu_err are ignored outside RUN.

Test Plan:
- Length 0x02, then bytes 78 56 34 12 EF BE AD DE → imem_we pulses twice: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF. The cycle after the 2nd write, cpu_reset=0 and busy=1.
- Same load, cpu_done raised on the 10th RUN cycle → status=01, cycle_count=10, cpu_reset=1 on the next cycle, busy=0.
- cpu_err and cpu_done rise in the same RUN cycle → status=10.
- Neither flag ever rises → status=11 after exactly TIMEOUT RUN cycles; cpu_reset returns to 1.
- Length 0x00 with 1024 data bytes → 256 writes, addresses 0..255, then RUN; rx_valid toggled randomly must not alter the data.
- reset pulled low after 5 of 8 data bytes → all outputs at reset values with no write strobe. A new load after release must write from addr 0; a new length byte in HALT must clear status to 00.
